// File: rtl/k_fifo_pkg_t1.sv
// Shared definitions for the k_fifo family: prefetch-buffer state encoding
// and the default word/address widths used by the FIFO and its drain engine.
package k_fifo_pkg_t1;

  localparam int DATA_SIZE = 8;
  localparam int ADDR_SIZE = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/k_skid2_t1.sv
// Two-entry prefetch buffer: a write side (wr_valid/wr_ready) filled from the
// FIFO and a registered read side (rd_valid/rd_ready) that never bubbles.
import k_fifo_pkg_t1::*;

module k_skid2_t1 #(
  parameter int data_size = DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 wr_valid,
  input  logic [data_size-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 rd_valid,
  output logic [data_size-1:0] rd_data,
  input  logic                 rd_ready
);

  buf_state_e           state, state_nxt;
  logic [data_size-1:0] head, tail, head_nxt, tail_nxt;
  logic                 push, pop;

  assign rd_valid = (state != EMPTY);
  assign rd_data  = head;
  assign pop      = rd_valid && rd_ready;
  // A full buffer can still take a word in the same cycle the head leaves.
  assign wr_ready = (state != TWO) || pop;
  assign push     = wr_valid && wr_ready;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    case (state)
      EMPTY: begin
        if (push) begin
          head_nxt  = wr_data;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_nxt = wr_data;
        end else if (push) begin
          tail_nxt  = wr_data;
          state_nxt = TWO;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_nxt = tail;
          if (push) tail_nxt  = wr_data;
          else      state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (clear) state_nxt = EMPTY;
  end

  // NOTE: the two data registers are reset as well so out_data reads 0 after reset;
  // non-blocking assignments keep all flops updating from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

endmodule

// File: rtl/k_fifo_rd_stream_t1.sv
// Read-side drain engine: FIFO pop control, burst framing and flush.
// Optional delivered-word counter enabled by defining K_FIFO_RD_CNT_EN.
import k_fifo_pkg_t1::*;

module k_fifo_rd_stream_t1 #(
  parameter int data_size = DATA_SIZE,
  parameter int burst_len = 4,
  parameter int cnt_size  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [data_size-1:0] rdata,
  input  logic                 rempty,
  output logic                 rget,
  input  logic                 rflush,
  output logic [data_size-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [cnt_size-1:0]  rcnt
);

  localparam int                beat_w   = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [beat_w-1:0] beat_max = beat_w'(burst_len - 1);

  logic              wr_valid, wr_ready, accept;
  logic [beat_w-1:0] beat;

  assign wr_valid = !rempty && !rflush;
  assign rget     = wr_valid && wr_ready;
  assign accept   = out_valid && out_ready;

  k_skid2_t1 #(.data_size(data_size)) u_skid (
    .clk      (rclk),
    .rst      (rrst),
    .clear    (rflush),
    .wr_valid (wr_valid),
    .wr_data  (rdata),
    .wr_ready (wr_ready),
    .rd_valid (out_valid),
    .rd_data  (out_data),
    .rd_ready (out_ready)
  );

  // Flush takes priority over an accept landing in the same cycle.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst)                          beat <= '0;
    else if (rflush)                   beat <= '0;
    else if (accept && beat == beat_max) beat <= '0;
    else if (accept)                   beat <= beat + beat_w'(1);
  end

  assign out_last = out_valid && (beat == beat_max);

`ifdef K_FIFO_RD_CNT_EN
  logic [cnt_size-1:0] cnt;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst)        cnt <= '0;
    else if (rflush) cnt <= '0;
    else if (accept) cnt <= cnt + cnt_size'(1);
  end

  assign rcnt = cnt;
`else
  assign rcnt = '0;
`endif

endmodule
